boost_pwm_modulator: RTL and testbench
======================================

BOOST_PWM_MODULATOR -- requirements
Module: boost_pwm_modulator

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning.
- counter_width, 32, width of period/counter.
- data_width, 32, width of duty word.
- data_decimal, 22, fractional bits of duty word.
- dt_width, 8, width of dead-time value.

REQ-002 SHALL have ports, one per line: name, direction, width, meaning.
- aclk, in, 1, single clock, rising edge.
- reset, in, 1, asynchronous, active-high reset.
- enable, in, 1, run request.
- period, in, counter_width, PWM period in aclk cycles.
- deadtime, in, dt_width, dead time in aclk cycles.
- duty, in, data_width, signed fixed-point duty (data_decimal fractional bits).
- duty_valid, in, 1, duty offered.
- duty_ready, out, 1, duty can be accepted.
- counter, out, counter_width, carrier counter.
- period_start, out, 1, one-cycle pulse at counter==0.
- S1_pwm, out, 1, high-side gate.
- S1n_pwm, out, 1, complementary gate.

Function
REQ-003 SHALL implement an FSM with two states:
- IDLE: counter=0, all gates low.
- RUN: entered from IDLE on the edge sampling enable=1. RUN returns to IDLE on the edge sampling enable=0.

REQ-004 SHALL, on entry to RUN, latch period into period_sh, with counter=0 in the first RUN cycle.

REQ-005 SHALL, in RUN, increment counter each cycle and wrap to 0 after period_sh-1. At each wrap, period_sh reloads from period.

REQ-006 SHALL treat a latched period_sh below 2 as 2.

REQ-007 SHALL assert period_start for exactly one cycle whenever counter==0 in RUN.

REQ-008 SHALL accept a duty word on a cycle with duty_valid=1 and duty_ready=1.

REQ-009 SHALL clamp an accepted duty to the range 0 to 2^data_decimal (negative becomes 0, above 1.0 becomes 1.0).

REQ-010 SHALL compute the pending comparator as (clamped duty × period_sh) >> data_decimal. The product is kept at data_width+counter_width bits with no overflow, and the result is ready 1 cycle after acceptance.

REQ-011 SHALL drive duty_ready low from acceptance until the pending comparator is applied. The comparator is applied at the next wrap, or immediately if in IDLE. duty_ready returns high the cycle after application.

REQ-012 SHALL define raw = (counter < comparator_active), evaluated only in RUN.

REQ-013 SHALL, for dead-time insertion:
- raise S1_pwm only after raw has been continuously 1 for deadtime cycles;
- raise S1n_pwm only after raw has been continuously 0 for deadtime cycles;
- drop either gate on the first cycle its condition fails.

REQ-014 SHALL never assert S1_pwm and S1n_pwm simultaneously.

REQ-015 SHALL, with deadtime=0, register S1_pwm=raw and S1n_pwm=~raw with 1-cycle latency.

REQ-016 SHALL keep a gate low when the raw pulse is shorter than or equal to deadtime.

REQ-017 SHALL make 0% duty give S1_pwm permanently low and 100% duty give S1n_pwm permanently low.

REQ-018 SHALL register all outputs. Gate latency from raw is 1 cycle plus dead time.

REQ-019 SHALL, on an enable drop mid-period, drive both gates low and counter to 0 on the following edge. A pending duty is retained.

Reset
REQ-020 SHALL, while reset=1, asynchronously force:
- FSM to IDLE;
- counter, period_sh and comparator_active to 0;
- all gates and period_start low;
- the pending flag to clear and duty_ready high.

REQ-021 SHALL resume from IDLE at the first edge after reset deasserts, with no accepted duty.

Verification
REQ-022 SHALL cover: period=1000, deadtime=0, duty=0x00080000 (0.125) -> comparator=125; S1_pwm high 125 of 1000 cycles; S1n_pwm high 875.

REQ-023 SHALL cover: same settings with deadtime=10 -> S1_pwm high 115 cycles, S1n_pwm high 865, 10-cycle both-low gaps on each edge, no overlap.

REQ-024 SHALL cover: duty changed to 0x00200000 (0.5) mid-period -> old 125 holds until wrap; next period has 500 high cycles; duty_ready low until wrap.

REQ-025 SHALL cover duty boundary values with period=1000:
- duty=-1.0 -> S1_pwm never high;
- duty=0x00800000 (2.0) -> clamped to 1.0, S1n_pwm never high;
- duty=0.005, deadtime=10 (comparator=5) -> S1_pwm stays low.

REQ-026 SHALL cover: enable dropped at counter=300, then raised -> gates low and counter=0 next edge; restart at counter=0 with period_start pulse.

REQ-027 SHALL cover: reset asserted mid-pulse between clock edges -> outputs low immediately; duty_ready high; after release the S1_pwm gate remains low until a new duty is accepted.

Source files
------------

// File: rtl/boost_pwm_modulator.sv
// Boost-converter PWM modulator: sawtooth carrier, duty handshake with
// fixed-point clamp/scale, and complementary gates with dead-time insertion.
module boost_pwm_modulator #(
   parameter int unsigned counter_width = 32,
   parameter int unsigned data_width    = 32,
   parameter int unsigned data_decimal  = 22,
   parameter int unsigned dt_width      = 8
) (
   input  logic                     aclk,
   input  logic                     reset,
   input  logic                     enable,
   input  logic [counter_width-1:0] period,
   input  logic [dt_width-1:0]      deadtime,
   input  logic [data_width-1:0]    duty,
   input  logic                     duty_valid,
   output logic                     duty_ready,
   output logic [counter_width-1:0] counter,
   output logic                     period_start,
   output logic                     S1_pwm,
   output logic                     S1n_pwm
);

   localparam int unsigned pw = data_width + counter_width;
   localparam int unsigned rw = dt_width + 1;
   localparam logic [data_width-1:0] duty_one = data_width'(1) << data_decimal;

   typedef enum logic {st_idle, st_run} state_t;

   state_t                   state_q, state_d;
   logic [counter_width-1:0] counter_d;
   logic [counter_width-1:0] period_sh, period_sh_d;
   logic [counter_width-1:0] cmp_active, cmp_active_d;
   logic [counter_width-1:0] cmp_pending, cmp_pending_d;
   logic                     pend_valid, pend_valid_d;
   logic [data_width-1:0]    duty_hold, duty_hold_d;
   logic                     mult_busy, mult_busy_d;
   logic                     duty_ready_d;
   logic [rw-1:0]            hi_run, hi_run_d;
   logic [rw-1:0]            lo_run, lo_run_d;
   logic                     period_start_d, s1_d, s1n_d;

   logic [counter_width-1:0] period_eff;
   logic [pw-1:0]            product;
   logic                     wrap, apply, raw;
   logic [rw-1:0]            hi_len, lo_len;

   // State and datapath registers
   always_ff @(posedge aclk or posedge reset) begin
      if (reset) begin
         state_q      <= st_idle;
         counter      <= '0;
         period_sh    <= '0;
         cmp_active   <= '0;
         cmp_pending  <= '0;
         pend_valid   <= 1'b0;
         duty_hold    <= '0;
         mult_busy    <= 1'b0;
         duty_ready   <= 1'b1;
         hi_run       <= '0;
         lo_run       <= '0;
         period_start <= 1'b0;
         S1_pwm       <= 1'b0;
         S1n_pwm      <= 1'b0;
      end else begin
         state_q      <= state_d;
         counter      <= counter_d;
         period_sh    <= period_sh_d;
         cmp_active   <= cmp_active_d;
         cmp_pending  <= cmp_pending_d;
         pend_valid   <= pend_valid_d;
         duty_hold    <= duty_hold_d;
         mult_busy    <= mult_busy_d;
         duty_ready   <= duty_ready_d;
         hi_run       <= hi_run_d;
         lo_run       <= lo_run_d;
         period_start <= period_start_d;
         S1_pwm       <= s1_d;
         S1n_pwm      <= s1n_d;
      end
   end

   // Next-state: carrier FSM, duty pipeline, dead-time gate logic
   always_comb begin
      state_d        = state_q;
      counter_d      = counter;
      period_sh_d    = period_sh;
      cmp_active_d   = cmp_active;
      cmp_pending_d  = cmp_pending;
      pend_valid_d   = pend_valid;
      duty_hold_d    = duty_hold;
      mult_busy_d    = mult_busy;
      duty_ready_d   = duty_ready;
      hi_run_d       = '0;
      lo_run_d       = '0;
      period_start_d = 1'b0;
      s1_d           = 1'b0;
      s1n_d          = 1'b0;
      wrap           = 1'b0;

      // Periods below 2 would make the start pulse last more than one cycle
      period_eff = (period < counter_width'(2)) ? counter_width'(2) : period;
      product    = pw'(duty_hold) * pw'(period_sh);

      case (state_q)
         st_idle: begin
            counter_d = '0;
            if (enable) begin
               state_d     = st_run;
               period_sh_d = period_eff;
            end
         end
         st_run: begin
            if (!enable) begin
               state_d   = st_idle;
               counter_d = '0;
            end else if (counter == period_sh - counter_width'(1)) begin
               counter_d   = '0;
               period_sh_d = period_eff;
               wrap        = 1'b1;
            end else begin
               counter_d = counter + counter_width'(1);
            end
         end
         default: state_d = st_idle;
      endcase

      // Accept: clamp to [0, 1.0]; scale on the following cycle
      if (duty_valid && duty_ready) begin
         if (duty[data_width-1])
            duty_hold_d = '0;
         else if (duty > duty_one)
            duty_hold_d = duty_one;
         else
            duty_hold_d = duty;
         mult_busy_d  = 1'b1;
         duty_ready_d = 1'b0;
      end
      if (mult_busy) begin
         cmp_pending_d = counter_width'(product >> data_decimal);
         pend_valid_d  = 1'b1;
         mult_busy_d   = 1'b0;
      end

      // New compare level takes effect only at a period boundary (or while idle)
      apply = pend_valid && (wrap || state_q == st_idle);
      if (apply) begin
         cmp_active_d = cmp_pending;
         pend_valid_d = 1'b0;
         duty_ready_d = 1'b1;
      end

      // Run lengths include the current cycle; a gate opens once its run exceeds deadtime
      raw    = (state_q == st_run) && (counter < cmp_active);
      hi_len = '0;
      lo_len = '0;
      if (raw)
         hi_len = (hi_run == '1) ? hi_run : hi_run + rw'(1);
      else if (state_q == st_run)
         lo_len = (lo_run == '1) ? lo_run : lo_run + rw'(1);

      if (state_d == st_run) begin
         hi_run_d       = hi_len;
         lo_run_d       = lo_len;
         s1_d           = hi_len > rw'(deadtime);
         s1n_d          = lo_len > rw'(deadtime);
         period_start_d = (counter_d == '0);
      end
   end

endmodule

// File: tb/tb_boost_pwm_modulator.sv
// Directed self-checking bench for boost_pwm_modulator.
module tb_boost_pwm_modulator;

   logic        aclk = 1'b0;
   logic        reset;
   logic        enable;
   logic [31:0] period;
   logic [7:0]  deadtime;
   logic [31:0] duty;
   logic        duty_valid;
   logic        duty_ready;
   logic [31:0] counter;
   logic        period_start;
   logic        S1_pwm;
   logic        S1n_pwm;

   int checks = 0;
   int errors = 0;
   int h, l, b, o;

   boost_pwm_modulator dut (
      .aclk         (aclk),
      .reset        (reset),
      .enable       (enable),
      .period       (period),
      .deadtime     (deadtime),
      .duty         (duty),
      .duty_valid   (duty_valid),
      .duty_ready   (duty_ready),
      .counter      (counter),
      .period_start (period_start),
      .S1_pwm       (S1_pwm),
      .S1n_pwm      (S1n_pwm)
   );

   always #5 aclk = ~aclk;

   task automatic check(input string tag, input longint got, input longint exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Offer one duty word at a negedge; it is taken at the next posedge
   task automatic send_duty(input logic [31:0] val);
      duty       = val;
      duty_valid = 1'b1;
      check("ready_before_accept", duty_ready, 1);
      @(negedge aclk);
      duty_valid = 1'b0;
      check("ready_after_accept", duty_ready, 0);
   endtask

   // Advance to the next negedge showing period_start
   task automatic wait_ps(input string tag);
      bit seen = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge aclk);
         if (period_start) begin
            seen = 1'b1;
            break;
         end
      end
      check(tag, seen, 1);
   endtask

   // Sample 1000 consecutive cycles starting at the current negedge
   task automatic measure(output int hi, output int lo, output int bl, output int ov);
      hi = 0; lo = 0; bl = 0; ov = 0;
      for (int i = 0; i < 1000; i++) begin
         if (S1_pwm) hi++;
         if (S1n_pwm) lo++;
         if (!S1_pwm && !S1n_pwm) bl++;
         if (S1_pwm && S1n_pwm) ov++;
         @(negedge aclk);
      end
   endtask

   initial begin
      reset = 1'b1; enable = 1'b0; period = 32'd1000; deadtime = 8'd0;
      duty = '0; duty_valid = 1'b0;
      repeat (3) @(negedge aclk);
      check("rst_s1", S1_pwm, 0);
      check("rst_s1n", S1n_pwm, 0);
      check("rst_counter", counter, 0);
      check("rst_ps", period_start, 0);
      check("rst_ready", duty_ready, 1);

      reset = 1'b0;
      @(negedge aclk);
      enable = 1'b1;
      @(negedge aclk);
      check("start_counter", counter, 0);
      check("start_ps", period_start, 1);
      @(negedge aclk);
      check("second_counter", counter, 1);
      check("second_ps", period_start, 0);

      // 0.125 duty, no dead time
      send_duty(32'h0008_0000);
      wait_ps("ps_apply_125");
      check("ready_at_wrap", duty_ready, 1);
      measure(h, l, b, o);
      check("d0_hi", h, 125);
      check("d0_lo", l, 875);
      check("d0_overlap", o, 0);

      // dead time 10
      deadtime = 8'd10;
      measure(h, l, b, o);
      measure(h, l, b, o);
      check("dt10_hi", h, 115);
      check("dt10_lo", l, 865);
      check("dt10_gaps", b, 20);
      check("dt10_overlap", o, 0);

      // duty changed to 0.5 mid-period
      deadtime = 8'd0;
      measure(h, l, b, o);
      repeat (400) @(negedge aclk);
      check("mid_counter", counter, 400);
      send_duty(32'h0020_0000);
      begin
         bit rdy_seen = 1'b0;
         bit s1_seen  = 1'b0;
         bit ps_seen  = 1'b0;
         for (int i = 0; i < 2000; i++) begin
            @(negedge aclk);
            if (period_start) begin
               ps_seen = 1'b1;
               break;
            end
            if (duty_ready) rdy_seen = 1'b1;
            if (S1_pwm) s1_seen = 1'b1;
         end
         check("ps_apply_500", ps_seen, 1);
         check("ready_low_until_wrap", rdy_seen, 0);
         check("old_cmp_holds", s1_seen, 0);
      end
      check("ready_after_wrap_500", duty_ready, 1);
      measure(h, l, b, o);
      check("half_hi", h, 500);
      check("half_lo", l, 500);

      // -1.0 clamps to 0
      send_duty(32'hFFC0_0000);
      wait_ps("ps_neg");
      measure(h, l, b, o);
      measure(h, l, b, o);
      check("neg_hi", h, 0);
      check("neg_lo", l, 1000);

      // 2.0 clamps to 1.0
      send_duty(32'h0080_0000);
      wait_ps("ps_two");
      measure(h, l, b, o);
      measure(h, l, b, o);
      check("full_hi", h, 1000);
      check("full_lo", l, 0);

      // 0.005 with dead time 10: 5-cycle pulse swallowed
      deadtime = 8'd10;
      send_duty(32'h0000_51EC);
      wait_ps("ps_tiny");
      measure(h, l, b, o);
      measure(h, l, b, o);
      check("tiny_hi", h, 0);
      check("tiny_lo", l, 985);

      // enable drop at counter 300
      deadtime = 8'd0;
      send_duty(32'h0020_0000);
      wait_ps("ps_half2");
      measure(h, l, b, o);
      repeat (300) @(negedge aclk);
      check("drop_counter", counter, 300);
      check("drop_s1_before", S1_pwm, 1);
      enable = 1'b0;
      @(negedge aclk);
      check("drop_counter0", counter, 0);
      check("drop_s1", S1_pwm, 0);
      check("drop_s1n", S1n_pwm, 0);
      check("drop_ps", period_start, 0);
      enable = 1'b1;
      @(negedge aclk);
      check("restart_counter", counter, 0);
      check("restart_ps", period_start, 1);
      @(negedge aclk);
      check("restart_counter1", counter, 1);

      // asynchronous reset mid-pulse
      repeat (98) @(negedge aclk);
      check("pre_rst_s1", S1_pwm, 1);
      #2 reset = 1'b1;
      #1;
      check("arst_s1", S1_pwm, 0);
      check("arst_s1n", S1n_pwm, 0);
      check("arst_counter", counter, 0);
      check("arst_ready", duty_ready, 1);
      check("arst_ps", period_start, 0);
      @(negedge aclk);
      reset = 1'b0;
      wait_ps("ps_after_rst");
      measure(h, l, b, o);
      check("post_rst_hi", h, 0);
      measure(h, l, b, o);
      check("post_rst_lo", l, 1000);
      send_duty(32'h0008_0000);
      wait_ps("ps_post_rst_duty");
      measure(h, l, b, o);
      check("post_rst_duty_hi", h, 125);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
